// File: rtl/hack_pkg.sv
// Shared definitions for the Hack control sequencer: FSM states, instruction
// field positions and jump codes.
package hack_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MWAIT = 2'd2
  } state_e;

  localparam int IS_C    = 15;
  localparam int A_BIT   = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_A  = 5;
  localparam int DEST_D  = 4;
  localparam int DEST_M  = 3;
  localparam int J_LT    = 2;
  localparam int J_EQ    = 1;
  localparam int J_GT    = 0;

  localparam logic [2:0] JMP_NULL = 3'b000;
  localparam logic [2:0] JMP_JGT  = 3'b001;
  localparam logic [2:0] JMP_JEQ  = 3'b010;
  localparam logic [2:0] JMP_JGE  = 3'b011;
  localparam logic [2:0] JMP_JLT  = 3'b100;
  localparam logic [2:0] JMP_JNE  = 3'b101;
  localparam logic [2:0] JMP_JLE  = 3'b110;
  localparam logic [2:0] JMP_JMP  = 3'b111;

  function automatic logic [5:0] comp_bits(input logic [15:0] ir);
    return ir[COMP_HI:COMP_LO];
  endfunction

endpackage

// File: rtl/hack_ctrl_seq_if.sv
// Fetch, ALU-control and memory-write signals between the sequencer (master)
// and its environment (slave). The halted flag exists only with HACK_HALT_DETECT_EN.
interface hack_ctrl_seq_if #(
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 15
) ();

  logic [BUS_WIDTH-1:0]  instr;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] a_val;
  logic                  zr;
  logic                  ng;
  logic                  zx, nx, zy, ny, f, no;
  logic                  sel_am;
  logic                  load_a;
  logic                  a_src;
  logic [BUS_WIDTH-1:0]  a_imm;
  logic                  load_d;
  logic                  m_wr_valid;
  logic                  m_wr_ready;
`ifdef HACK_HALT_DETECT_EN
  logic                  halted;
`endif

  modport master (
    input  instr, instr_valid, a_val, zr, ng, m_wr_ready,
    output instr_ready, pc, zx, nx, zy, ny, f, no, sel_am,
           load_a, a_src, a_imm, load_d, m_wr_valid
`ifdef HACK_HALT_DETECT_EN
    , output halted
`endif
  );

  modport slave (
    output instr, instr_valid, a_val, zr, ng, m_wr_ready,
    input  instr_ready, pc, zx, nx, zy, ny, f, no, sel_am,
           load_a, a_src, a_imm, load_d, m_wr_valid
`ifdef HACK_HALT_DETECT_EN
    , input halted
`endif
  );

endinterface

// File: rtl/hack_jump_eval.sv
// Combinational Hack jump condition from the three jump bits and ALU flags.
module hack_jump_eval
  import hack_pkg::*;
(
  input  logic [2:0] jbits_i,
  input  logic       zr_i,
  input  logic       ng_i,
  output logic       jump_o
);

  // Flags are combined bitwise so inconsistent zr/ng pairs still follow the equation.
  always_comb begin
    jump_o = (jbits_i[J_LT] & ng_i)
           | (jbits_i[J_EQ] & zr_i)
           | (jbits_i[J_GT] & ~ng_i & ~zr_i);
  end

endmodule

// File: rtl/hack_ctrl_seq.sv
// Multi-cycle Hack control sequencer: FETCH -> EXEC (-> MWAIT) -> FETCH.
// Optional HACK_HALT_DETECT_EN adds a sticky halt on an unconditional self-jump.
module hack_ctrl_seq
  import hack_pkg::*;
#(
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 15
) (
  input logic             clk,
  input logic             rst,
  hack_ctrl_seq_if.master bus
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic [BUS_WIDTH-1:0]  ir_q;
  logic                  run_q;
  logic                  halted_q;

  logic                  jump_s;
  logic                  c_active_s;
  logic                  c_done_s;
  logic                  a_done_s;
  logic                  ready_s;
  logic                  halt_s;
  logic [ADDR_WIDTH-1:0] pc_inc_s;

  hack_jump_eval u_jump (
    .jbits_i (ir_q[J_LT:J_GT]),
    .zr_i    (bus.zr),
    .ng_i    (bus.ng),
    .jump_o  (jump_s)
  );

  assign pc_inc_s   = pc_q + ADDR_WIDTH'(1);
  assign c_active_s = ir_q[IS_C] && ((state_q == ST_EXEC) || (state_q == ST_MWAIT));
  assign c_done_s   = c_active_s && (!ir_q[DEST_M] || bus.m_wr_ready);
  assign a_done_s   = !ir_q[IS_C] && (state_q == ST_EXEC);
  assign pc_d       = jump_s ? bus.a_val : pc_inc_s;

`ifdef HACK_HALT_DETECT_EN
  assign halt_s = c_done_s && (ir_q[J_LT:J_GT] == JMP_JMP) && (bus.a_val == pc_q);
`else
  assign halt_s = 1'b0;
`endif

  // run_q keeps instr_ready low while rst is high and until the first clock after release.
  assign ready_s = (state_q == ST_FETCH) && run_q && !halted_q;

  // Sequencer state, program counter and instruction register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      run_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case (state_q)
        ST_FETCH: begin
          if (ready_s && bus.instr_valid) begin
            ir_q    <= bus.instr;
            state_q <= ST_EXEC;
          end else begin
            state_q <= ST_FETCH;
          end
        end
        ST_EXEC, ST_MWAIT: begin
          if (a_done_s) begin
            pc_q    <= pc_inc_s;
            state_q <= ST_FETCH;
          end else if (c_done_s) begin
            pc_q     <= pc_d;
            state_q  <= ST_FETCH;
            halted_q <= halted_q | halt_s;
          end else begin
            state_q <= ST_MWAIT;
          end
        end
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  // Output decode from registered state; strobes pulse only in the completion cycle.
  always_comb begin
    bus.instr_ready = ready_s;
    bus.pc          = pc_q;
    {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = 6'b000000;
    bus.sel_am      = 1'b0;
    bus.m_wr_valid  = 1'b0;
    bus.load_a      = 1'b0;
    bus.a_src       = 1'b0;
    bus.load_d      = 1'b0;
    bus.a_imm       = '0;
    if (c_active_s) begin
      {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = comp_bits(ir_q);
      bus.sel_am     = ir_q[A_BIT];
      bus.m_wr_valid = ir_q[DEST_M];
    end else begin
      bus.sel_am     = 1'b0;
    end
    if (c_done_s) begin
      bus.load_a = ir_q[DEST_A];
      bus.a_src  = 1'b1;
      bus.load_d = ir_q[DEST_D];
    end else if (a_done_s) begin
      bus.load_a = 1'b1;
      bus.a_src  = 1'b0;
      bus.a_imm  = BUS_WIDTH'(ir_q[ADDR_WIDTH-1:0]);
    end else begin
      bus.load_a = 1'b0;
    end
  end

`ifdef HACK_HALT_DETECT_EN
  assign bus.halted = halted_q;
`endif

endmodule

// File: tb/tb_hack_ctrl_seq.sv
// Directed scoreboard bench for hack_ctrl_seq (default and HACK_HALT_DETECT_EN builds).
module tb_hack_ctrl_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hack_ctrl_seq_if #(.BUS_WIDTH(16), .ADDR_WIDTH(15)) bus ();
  hack_ctrl_seq #(.BUS_WIDTH(16), .ADDR_WIDTH(15)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [14:0] next_pc;
    logic        load_a;
    logic        a_src;
    logic        load_d;
    logic        sel_am;
    logic        mwr;
    logic        rdy_after;
    logic [5:0]  ctrl;
    logic [15:0] a_imm;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [14:0] model_pc = 15'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] ctrl_obs();
    return {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no};
  endfunction

  function automatic exp_t model(input logic [15:0] ins, input logic [14:0] aval,
                                 input logic z, input logic n, input logic [14:0] pc);
    exp_t e;
    logic j;
    e = '0;
    e.rdy_after = 1'b1;
    if (!ins[15]) begin
      e.load_a  = 1'b1;
      e.a_imm   = {1'b0, ins[14:0]};
      e.next_pc = pc + 15'd1;
    end else begin
      e.sel_am  = ins[12];
      e.ctrl    = ins[11:6];
      e.load_a  = ins[5];
      e.a_src   = 1'b1;
      e.load_d  = ins[4];
      e.mwr     = ins[3];
      j = (ins[2] & n) | (ins[1] & z) | (ins[0] & ~n & ~z);
      e.next_pc = j ? aval : pc + 15'd1;
`ifdef HACK_HALT_DETECT_EN
      if (ins[2:0] == 3'b111 && aval == pc) e.rdy_after = 1'b0;
`endif
    end
    return e;
  endfunction

  task automatic run_instr(input string tag, input logic [15:0] ins, input logic [14:0] aval,
                           input logic z, input logic n, input int stall);
    exp_t e;
    sb.push_back(model(ins, aval, z, n, model_pc));
    chk({tag, ":ready_before"}, 32'(bus.instr_ready), 32'd1);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    bus.a_val       = aval;
    bus.zr          = z;
    bus.ng          = n;
    bus.m_wr_ready  = (stall == 0);
    step();
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    for (int i = 0; i < stall; i++) begin
      #1;
      chk({tag, ":stall_ready"}, 32'(bus.instr_ready), 32'd0);
      chk({tag, ":stall_mwv"}, 32'(bus.m_wr_valid), 32'd1);
      chk({tag, ":stall_ctrl"}, 32'(ctrl_obs()), 32'(ins[11:6]));
      chk({tag, ":stall_strobes"}, 32'({bus.load_a, bus.load_d}), 32'd0);
      chk({tag, ":stall_pc"}, 32'(bus.pc), 32'(model_pc));
      step();
    end
    bus.m_wr_ready = 1'b1;
    #1;
    e = sb.pop_front();
    chk({tag, ":exec_ready"}, 32'(bus.instr_ready), 32'd0);
    chk({tag, ":load_a"}, 32'(bus.load_a), 32'(e.load_a));
    chk({tag, ":a_src"}, 32'(bus.a_src), 32'(e.a_src));
    chk({tag, ":load_d"}, 32'(bus.load_d), 32'(e.load_d));
    chk({tag, ":a_imm"}, 32'(bus.a_imm), 32'(e.a_imm));
    chk({tag, ":ctrl"}, 32'(ctrl_obs()), 32'(e.ctrl));
    chk({tag, ":sel_am"}, 32'(bus.sel_am), 32'(e.sel_am));
    chk({tag, ":mwv"}, 32'(bus.m_wr_valid), 32'(e.mwr));
    chk({tag, ":pc_hold"}, 32'(bus.pc), 32'(model_pc));
    step();
    bus.m_wr_ready = 1'b0;
    chk({tag, ":pc_next"}, 32'(bus.pc), 32'(e.next_pc));
    chk({tag, ":ready_after"}, 32'(bus.instr_ready), 32'(e.rdy_after));
    chk({tag, ":load_a_pulse"}, 32'(bus.load_a), 32'd0);
    model_pc = e.next_pc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    bus.instr       = 16'h0000;
    bus.instr_valid = 1'b0;
    bus.a_val       = 15'd0;
    bus.zr          = 1'b0;
    bus.ng          = 1'b0;
    bus.m_wr_ready  = 1'b0;
    #2;
    chk("rst:pc", 32'(bus.pc), 32'd0);
    chk("rst:ready", 32'(bus.instr_ready), 32'd0);
    chk("rst:ctrl", 32'(ctrl_obs()), 32'd0);
    chk("rst:strobes", 32'({bus.load_a, bus.load_d, bus.m_wr_valid, bus.sel_am, bus.a_src}), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("rel:ready", 32'(bus.instr_ready), 32'd1);
    chk("rel:pc", 32'(bus.pc), 32'd0);

    run_instr("a_imm5",   16'h0005, 15'h0000, 1'b0, 1'b0, 0);
    run_instr("d_eq_a",   16'hEC10, 15'h0000, 1'b0, 1'b0, 0);
    run_instr("jmp",      16'hEA87, 15'h0010, 1'b1, 1'b0, 0);
    run_instr("jgt_no",   16'hE301, 15'h0040, 1'b0, 1'b1, 0);
    run_instr("jgt_yes",  16'hE301, 15'h0040, 1'b0, 1'b0, 0);
    run_instr("jmp_top",  16'hEA87, 15'h7FFF, 1'b0, 1'b0, 0);
    run_instr("wrap",     16'h1234, 15'h0000, 1'b0, 1'b0, 0);
    run_instr("mwr_st3",  16'hE7C8, 15'h0020, 1'b0, 1'b0, 3);
    run_instr("mwr_st0",  16'hE308, 15'h0020, 1'b1, 1'b0, 0);
    run_instr("jeq_no",   16'hE302, 15'h0050, 1'b0, 1'b1, 0);

    // Asynchronous reset while an M-write is pending in EXEC.
    chk("abort:ready_before", 32'(bus.instr_ready), 32'd1);
    bus.instr       = 16'hE7C8;
    bus.instr_valid = 1'b1;
    bus.m_wr_ready  = 1'b0;
    step();
    bus.instr_valid = 1'b0;
    #1;
    chk("abort:mwv_pending", 32'(bus.m_wr_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort:mwv", 32'(bus.m_wr_valid), 32'd0);
    chk("abort:ctrl", 32'(ctrl_obs()), 32'd0);
    chk("abort:pc", 32'(bus.pc), 32'd0);
    chk("abort:ready", 32'(bus.instr_ready), 32'd0);
    chk("abort:strobes", 32'({bus.load_a, bus.load_d}), 32'd0);
    step();
    rst = 1'b0;
    step();
    model_pc = 15'd0;
    chk("abort:rel_ready", 32'(bus.instr_ready), 32'd1);
    chk("abort:rel_pc", 32'(bus.pc), 32'd0);

    run_instr("jmp3",     16'hEA87, 15'h0003, 1'b0, 1'b0, 0);
    run_instr("self_jmp", 16'hEA87, 15'h0003, 1'b0, 1'b0, 0);
`ifdef HACK_HALT_DETECT_EN
    chk("halt:flag", 32'(bus.halted), 32'd1);
    bus.instr       = 16'h0007;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt:ready", 32'(bus.instr_ready), 32'd0);
      chk("halt:pc", 32'(bus.pc), 32'd3);
    end
    bus.instr_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("halt:rst_flag", 32'(bus.halted), 32'd0);
    step();
    rst = 1'b0;
    step();
    model_pc = 15'd0;
    chk("halt:rel_ready", 32'(bus.instr_ready), 32'd1);
`else
    run_instr("after_self", 16'h0042, 15'h0000, 1'b0, 1'b0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hack_ctrl_seq.md
Name: hack_ctrl_seq

Overview:
- Multi-cycle control sequencer for the Hack-style CPU. It is the driving end of the ALU control interface.
- Fetches 16-bit instructions over a valid/ready handshake and decodes A- and C-instructions.
- Drives zx/nx/zy/ny/f/no to the alu, consumes the ALU zr/ng flags for jumps, and owns the program counter.
- Issues A/D register load strobes and a memory-write handshake.

Parameters:
- BUS_WIDTH, 16, data/instruction width; must be 16 for Hack encoding.
- ADDR_WIDTH, 15, PC and A-address width.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr  in  BUS_WIDTH  instruction word from instruction memory.
- instr_valid  in  1  instr is valid.
- instr_ready  out  1  sequencer accepts instr this cycle.
- pc  out  ADDR_WIDTH  address of the instruction to fetch.
- a_val  in  ADDR_WIDTH  current A register contents, used as jump target.
- zr  in  1  ALU out==0.
- ng  in  1  ALU out<0.
- zx, nx, zy, ny, f, no  out  1 each  ALU control bits.
- sel_am  out  1  ALU y operand: 0 selects A, 1 selects M.
- load_a  out  1  A register load strobe.
- a_src  out  1  A load source: 0 selects a_imm, 1 selects ALU out.
- a_imm  out  BUS_WIDTH  zero-extended immediate from an A-instruction.
- load_d  out  1  D register load strobe.
- m_wr_valid  out  1  write ALU out to M[A].
- m_wr_ready  in  1  memory accepts the write.

Behaviour:
- Reset (asynchronous, active-high rst): state=FETCH, pc=0, ir=0. Every output listed above is 0 while rst is high, including instr_ready. After rst falls, outputs decode from registered state, so instr_ready=1 in FETCH from the first clock onward.
- States:
  - FETCH:
    - instr_ready=1; all control outputs 0.
    - On instr_valid: ir<=instr, go to EXEC.
    - Otherwise stay in FETCH.
  - EXEC, A-instruction (ir[15]=0):
    - load_a=1, a_src=0, a_imm={1'b0, ir[14:0]}.
    - pc<=pc+1, go to FETCH. One cycle.
  - EXEC, C-instruction (ir[15]=1):
    - Combinational decode: sel_am=ir[12]; {zx,nx,zy,ny,f,no}=ir[11:6].
    - jump = (ir[2]&ng) | (ir[1]&zr) | (ir[0]&~ng&~zr), sampled this cycle.
    - If ir[3]=1: m_wr_valid=1.
    - The instruction completes when ir[3]=0, or when m_wr_ready=1 in the same cycle.
    - On completion: load_a=ir[5] with a_src=1, and load_d=ir[4], both pulsed for that cycle only. Then pc<=jump ? a_val : pc+1 (a_val is the pre-update A). Go to FETCH.
    - If not complete: go to MWAIT. load_a, load_d and pc are untouched.
  - MWAIT:
    - ALU controls, sel_am and m_wr_valid are held stable, and jump is re-evaluated each cycle.
    - On m_wr_ready: complete exactly as in EXEC.
- Throughput: 2 cycles per instruction with no stalls, i.e. one FETCH plus one EXEC cycle.
- pc increment wraps from 2^ADDR_WIDTH-1 to 0.
- ir[14:13] are ignored.
- Reset asserted mid-EXEC or mid-MWAIT aborts the instruction: no strobe and no pc update.

Optional Feature:
- HACK_HALT_DETECT_EN defined:
  - Adds output halted (1 bit, reset 0).
  - An unconditional jump to self sets halted sticky: ir=C-instruction with ir[2:0]=3'b111 and a_val==pc at completion.
  - While halted, instr_ready=0 and the FSM stays in FETCH until rst.
- Undefined: no halted port; self-jumps loop normally.

Decomposition:
- Shared package hack_pkg:
  - State encoding (FETCH/EXEC/MWAIT).
  - Instruction field bit positions (IS_C=15, A_BIT=12, COMP_HI=11, COMP_LO=6, DEST_A=5, DEST_D=4, DEST_M=3, J_LT=2, J_EQ=1, J_GT=0).
  - Jump code constants.
- Sub-module hack_jump_eval: combinational (jbits, zr, ng) -> jump. Reusable by a future pipelined core.

Test Plan:
- rst pulsed asynchronously mid-EXEC of 0xE7C8 -> all outputs 0 immediately; after release pc=0 and instr_ready=1.
- A-instr 0x0005 -> next cycle load_a=1, a_src=0, a_imm=0x0005 for one cycle; pc 0->1; instr_ready high again 2 cycles after accept.
- 0xEC10 (D=A) -> {zx,nx,zy,ny,f,no}=110000, sel_am=0, load_d=1, load_a=0, m_wr_valid=0; pc+1.
- 0xEA87 (0;JMP), a_val=0x0010, zr=1 -> pc=0x0010. 0xE301 (D;JGT) with ng=1 -> no jump, pc+1. Any fetch at pc=0x7FFF without a jump -> pc=0x0000.
- 0xE7C8 (M=D+1) with m_wr_ready low 3 cycles -> m_wr_valid high 4 cycles, controls 011111 stable throughout, pc updates only on the handshake cycle.
- HACK_HALT_DETECT_EN: 0xEA87 at pc=0x0003 with a_val=0x0003 -> halted=1, instr_ready stays 0 until rst.
